// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, LSU state type and lane helpers shared by the data-memory LSU
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RESP, SPLIT} lsu_state_t;

    // Byte enables over two adjacent words: [3:0] addressed word, [7:4] next word
    function automatic logic [7:0] be_gen(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] base;
        base = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
        return {4'b0000, base} << lo;
    endfunction

    // Select the lane at byte offset lo and sign/zero extend it to 32 bits
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [1:0] lo);
        logic [31:0] s;
        s = word >> {lo, 3'b000};
        return (f3 == F3_B)  ? {{24{s[7]}}, s[7:0]} :
               (f3 == F3_H)  ? {{16{s[15]}}, s[15:0]} :
               (f3 == F3_BU) ? {24'b0, s[7:0]} :
               (f3 == F3_HU) ? {16'b0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response bus between execute stage and the data-memory LSU
interface dmem_lsu_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sram.sv
// dmem_sram: 1R1W synchronous word RAM, byte write enables, write-first
module dmem_sram #(
    parameter int    WORDS     = 128,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic [$clog2(WORDS)-1:0] i_raddr,
    input  logic [$clog2(WORDS)-1:0] i_waddr,
    input  logic [3:0]               i_be,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);
    logic [31:0] r_mem [WORDS];

    // Byte-lane write; a read of the word being written returns the new bytes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            o_rdata[8*i +: 8] <= (i_be[i] && i_waddr == i_raddr) ? i_wdata[8*i +: 8]
                                                                  : r_mem[i_raddr][8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit over a byte-enabled RAM; define MISALIGN_SPLIT_EN to serve misaligned accesses
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int    ADDR_W    = 9,
    parameter int    DATA_W    = 32,
    parameter string INIT_FILE = ""
) (
    input logic       clk,
    input logic       reset,
    dmem_lsu_if.slave bus
);
    localparam int WA = ADDR_W - 2;

    if (DATA_W != 32) begin : g_width_chk
        $error("dmem_lsu: DATA_W must be 32");
    end

    lsu_state_t  r_state;
    logic        r_ready, r_err, r_rd;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic        w_accept, w_bad_f3, w_err, w_cross, w_st;
    logic [2:0]  w_f3;
    logic [1:0]  w_lo;
    logic [WA-1:0] w_word, w_raddr, w_waddr;
    logic [3:0]  w_be, w_ram_be;
    logic [31:0] w_wd, w_ram_wd, w_q, w_ld;

    assign w_f3     = bus.req_funct3;
    assign w_lo     = bus.req_addr[1:0];
    assign w_word   = bus.req_addr[ADDR_W-1:2];
    assign w_accept = bus.req_valid && r_ready && !reset;
    assign w_bad_f3 = bus.req_we ? !(w_f3 inside {F3_B, F3_H, F3_W})
                                 : !(w_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_be     = 4'(be_gen(w_f3, w_lo));
    assign w_wd     = bus.req_wdata << {w_lo, 3'b000};
    assign w_st     = w_accept && bus.req_we && !w_err;

`ifdef MISALIGN_SPLIT_EN
    logic          r_split, r_we;
    logic [WA-1:0] r_word;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wd_hi, r_first, w_join;
    logic          w_split_wr;
    logic [WA-1:0] w_next;

    assign w_err      = w_bad_f3;
    assign w_cross    = !w_bad_f3 && ((w_f3[1:0] == 2'b01 && w_lo == 2'b11) ||
                                      (w_f3[1:0] == 2'b10 && w_lo != 2'b00));
    assign w_next     = r_word + WA'(1);
    assign w_split_wr = r_state == SPLIT && r_we && !reset;
    assign w_raddr    = r_state == SPLIT ? w_next : w_word;
    assign w_waddr    = w_split_wr ? w_next : w_word;
    assign w_ram_be   = w_split_wr ? r_be_hi : w_st ? w_be : 4'b0000;
    assign w_ram_wd   = w_split_wr ? r_wd_hi : w_wd;
    assign w_join     = 32'({w_q, r_first} >> {r_lo, 3'b000});
    assign w_ld       = r_split ? load_ext(r_f3, w_join, 2'b00) : load_ext(r_f3, w_q, r_lo);
`else
    assign w_err    = w_bad_f3 || (w_f3[1:0] == 2'b01 && w_lo[0]) ||
                      (w_f3[1:0] == 2'b10 && w_lo != 2'b00);
    assign w_cross  = 1'b0;
    assign w_raddr  = w_word;
    assign w_waddr  = w_word;
    assign w_ram_be = w_st ? w_be : 4'b0000;
    assign w_ram_wd = w_wd;
    assign w_ld     = load_ext(r_f3, w_q, r_lo);
`endif

    dmem_sram #(.WORDS(2 ** WA), .INIT_FILE(INIT_FILE)) u_sram (
        .clk     (clk),
        .i_raddr (w_raddr),
        .i_waddr (w_waddr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wd),
        .o_rdata (w_q)
    );

    // Request FSM: capture response attributes on accept, hold off new requests during a split
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end
`ifdef MISALIGN_SPLIT_EN
        else if (r_state == SPLIT) begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_first <= w_q;
        end
`endif
        else if (w_accept) begin
            r_state <= w_cross ? SPLIT : RESP;
            r_ready <= !w_cross;
            r_err   <= w_err;
            r_rd    <= !bus.req_we && !w_err;
            r_f3    <= w_f3;
            r_lo    <= w_lo;
`ifdef MISALIGN_SPLIT_EN
            r_split <= w_cross;
            r_we    <= bus.req_we;
            r_word  <= w_word;
            r_be_hi <= 4'(be_gen(w_f3, w_lo) >> 4);
            r_wd_hi <= 32'(({32'b0, bus.req_wdata} << {w_lo, 3'b000}) >> 32);
`endif
        end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_state == RESP;
    assign bus.rsp_err   = r_state == RESP && r_err;
    assign bus.rsp_rdata = (r_state == RESP && r_rd) ? w_ld : '0;
endmodule
